// File: rtl/mmu_tlb.sv
// mmu_tlb: MIPS virtual-to-physical translator with one registered valid/ready stage.
// Define MMU_TLB_EN to build the fully-associative TLB; without it mapped segments translate by identity.
module mmu_tlb #(
    parameter int TLB_ENTRIES = 8,
    parameter int ASID_W      = 8,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic              req_wr,
    input  logic [ASID_W-1:0] cur_asid,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_paddr,
    output logic              resp_uncached,
    output logic              resp_miss,
    output logic              resp_invalid,
    output logic              resp_modified,
    input  logic              tlb_we,
    input  logic [IDX_W-1:0]  tlb_index,
    input  logic [19:0]       tlb_vpn,
    input  logic [ASID_W-1:0] tlb_asid,
    input  logic              tlb_g,
    input  logic [19:0]       tlb_pfn,
    input  logic              tlb_v,
    input  logic              tlb_d,
    input  logic              tlb_c,
    input  logic              tlb_flush
);

    logic        accept;
    logic        kseg;
    logic [31:0] x_paddr;
    logic        x_unc, x_miss, x_inv, x_mod;

    logic        vld_p1_q, vld_p1_d;
    logic [31:0] paddr_p1_q, paddr_p1_d;
    logic        unc_p1_q, unc_p1_d;
    logic        miss_p1_q, miss_p1_d;
    logic        inv_p1_q, inv_p1_d;
    logic        mod_p1_q, mod_p1_d;

    assign req_ready = !vld_p1_q || resp_ready;
    assign accept    = req_valid && req_ready;
    assign kseg      = (req_vaddr[31:30] == 2'b10);

`ifdef MMU_TLB_EN
    logic [19:0]       ent_vpn_q  [TLB_ENTRIES];
    logic [19:0]       ent_vpn_d  [TLB_ENTRIES];
    logic [ASID_W-1:0] ent_asid_q [TLB_ENTRIES];
    logic [ASID_W-1:0] ent_asid_d [TLB_ENTRIES];
    logic [19:0]       ent_pfn_q  [TLB_ENTRIES];
    logic [19:0]       ent_pfn_d  [TLB_ENTRIES];
    logic [TLB_ENTRIES-1:0] ent_live_q, ent_live_d;
    logic [TLB_ENTRIES-1:0] ent_g_q, ent_g_d;
    logic [TLB_ENTRIES-1:0] ent_v_q, ent_v_d;
    logic [TLB_ENTRIES-1:0] ent_dty_q, ent_dty_d;
    logic [TLB_ENTRIES-1:0] ent_c_q, ent_c_d;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;

    // Flush and reset retire entries outright, so they miss instead of raising an invalid fault.
    always_comb begin
        ent_vpn_d  = ent_vpn_q;
        ent_asid_d = ent_asid_q;
        ent_pfn_d  = ent_pfn_q;
        ent_live_d = ent_live_q;
        ent_g_d    = ent_g_q;
        ent_v_d    = ent_v_q;
        ent_dty_d  = ent_dty_q;
        ent_c_d    = ent_c_q;
        if (tlb_flush) begin
            ent_live_d = '0;
            ent_g_d    = '0;
            ent_v_d    = '0;
        end
        if (tlb_we) begin
            ent_vpn_d[tlb_index]  = tlb_vpn;
            ent_asid_d[tlb_index] = tlb_asid;
            ent_pfn_d[tlb_index]  = tlb_pfn;
            ent_live_d[tlb_index] = 1'b1;
            ent_g_d[tlb_index]    = tlb_g;
            ent_v_d[tlb_index]    = tlb_v;
            ent_dty_d[tlb_index]  = tlb_d;
            ent_c_d[tlb_index]    = tlb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_live_q <= '0;
            ent_g_q    <= '0;
            ent_v_q    <= '0;
        end else begin
            ent_live_q <= ent_live_d;
            ent_g_q    <= ent_g_d;
            ent_v_q    <= ent_v_d;
        end
        ent_vpn_q  <= ent_vpn_d;
        ent_asid_q <= ent_asid_d;
        ent_pfn_q  <= ent_pfn_d;
        ent_dty_q  <= ent_dty_d;
        ent_c_q    <= ent_c_d;
    end

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (ent_live_q[i] && ent_vpn_q[i] == req_vaddr[31:12] &&
                (ent_g_q[i] || ent_asid_q[i] == cur_asid)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end
`else
    logic unused_tlb;
    assign unused_tlb = ^{req_wr, cur_asid, tlb_we, tlb_index, tlb_vpn, tlb_asid, tlb_g,
                          tlb_pfn, tlb_v, tlb_d, tlb_c, tlb_flush};
`endif

    always_comb begin
        x_paddr = {3'b000, req_vaddr[28:0]};
        x_unc   = req_vaddr[29];
        x_miss  = 1'b0;
        x_inv   = 1'b0;
        x_mod   = 1'b0;
        if (!kseg) begin
`ifdef MMU_TLB_EN
            x_paddr = '0;
            x_unc   = 1'b0;
            if (!hit) begin
                x_miss = 1'b1;
            end else if (!ent_v_q[hit_idx]) begin
                x_inv = 1'b1;
            end else begin
                x_paddr = {ent_pfn_q[hit_idx], req_vaddr[11:0]};
                if (req_wr && !ent_dty_q[hit_idx]) begin
                    x_mod = 1'b1;
                end else begin
                    x_unc = !ent_c_q[hit_idx];
                end
            end
`else
            x_paddr = req_vaddr;
            x_unc   = 1'b0;
`endif
        end
    end

    // Stage p1: registered result, held while the consumer stalls.
    always_comb begin
        vld_p1_d   = vld_p1_q;
        paddr_p1_d = paddr_p1_q;
        unc_p1_d   = unc_p1_q;
        miss_p1_d  = miss_p1_q;
        inv_p1_d   = inv_p1_q;
        mod_p1_d   = mod_p1_q;
        if (accept) begin
            vld_p1_d   = 1'b1;
            paddr_p1_d = x_paddr;
            unc_p1_d   = x_unc;
            miss_p1_d  = x_miss;
            inv_p1_d   = x_inv;
            mod_p1_d   = x_mod;
        end else if (resp_ready) begin
            vld_p1_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q   <= 1'b0;
            paddr_p1_q <= '0;
            unc_p1_q   <= 1'b0;
            miss_p1_q  <= 1'b0;
            inv_p1_q   <= 1'b0;
            mod_p1_q   <= 1'b0;
        end else begin
            vld_p1_q   <= vld_p1_d;
            paddr_p1_q <= paddr_p1_d;
            unc_p1_q   <= unc_p1_d;
            miss_p1_q  <= miss_p1_d;
            inv_p1_q   <= inv_p1_d;
            mod_p1_q   <= mod_p1_d;
        end
    end

    assign resp_valid    = vld_p1_q;
    assign resp_paddr    = paddr_p1_q;
    assign resp_uncached = unc_p1_q;
    assign resp_miss     = miss_p1_q;
    assign resp_invalid  = inv_p1_q;
    assign resp_modified = mod_p1_q;

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: directed stimulus with a reference translation model feeding a response scoreboard.
`timescale 1ns/1ps
module tb_mmu_tlb;
    localparam int N  = 8;
    localparam int AW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_wr;
    logic [31:0]   req_vaddr;
    logic [AW-1:0] cur_asid;
    logic          resp_valid, resp_ready;
    logic [31:0]   resp_paddr;
    logic          resp_uncached, resp_miss, resp_invalid, resp_modified;
    logic          tlb_we, tlb_g, tlb_v, tlb_d, tlb_c, tlb_flush;
    logic [IW-1:0] tlb_index;
    logic [19:0]   tlb_vpn, tlb_pfn;
    logic [AW-1:0] tlb_asid;

    always #5 clk = ~clk;

    mmu_tlb #(.TLB_ENTRIES(N), .ASID_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_wr(req_wr), .cur_asid(cur_asid),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_paddr(resp_paddr),
        .resp_uncached(resp_uncached), .resp_miss(resp_miss),
        .resp_invalid(resp_invalid), .resp_modified(resp_modified),
        .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_vpn(tlb_vpn), .tlb_asid(tlb_asid),
        .tlb_g(tlb_g), .tlb_pfn(tlb_pfn), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_c(tlb_c),
        .tlb_flush(tlb_flush)
    );

    typedef struct packed {
        logic [31:0] paddr;
        logic        unc;
        logic        miss;
        logic        inv;
        logic        mod;
    } res_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_acc = 1'b0;

    logic [19:0]   m_vpn  [N];
    logic [AW-1:0] m_asid [N];
    logic [19:0]   m_pfn  [N];
    logic          m_live [N];
    logic          m_g    [N];
    logic          m_v    [N];
    logic          m_d    [N];
    logic          m_c    [N];

    function automatic res_t model(input logic [31:0] va, input logic wr, input logic [AW-1:0] asid);
        res_t r;
        r = '0;
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
            r.paddr = {3'b000, va[28:0]};
            r.unc   = (va[31:29] == 3'b101);
            return r;
        end
`ifdef MMU_TLB_EN
        begin
            int h;
            h = -1;
            for (int i = 0; i < N; i++)
                if (h < 0 && m_live[i] && m_vpn[i] == va[31:12] && (m_g[i] || m_asid[i] == asid))
                    h = i;
            if (h < 0) r.miss = 1'b1;
            else if (!m_v[h]) r.inv = 1'b1;
            else if (wr && !m_d[h]) begin
                r.mod   = 1'b1;
                r.paddr = {m_pfn[h], va[11:0]};
            end else begin
                r.paddr = {m_pfn[h], va[11:0]};
                r.unc   = !m_c[h];
            end
        end
`else
        begin
            logic unused_m;
            unused_m = wr ^ (^asid);
            r.paddr  = va;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record the accept decision and TLB update in the model, then return just after the edge.
    task automatic step();
        @(negedge clk);
        if (prev_acc) check("latency", 32'(resp_valid), 32'd1);
        if (rst) begin
            sb.delete();
            prev_acc = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_live[i] = 1'b0; m_v[i] = 1'b0; m_g[i] = 1'b0;
            end
        end else begin
            prev_acc = req_valid && req_ready;
            if (prev_acc) sb.push_back(model(req_vaddr, req_wr, cur_asid));
            if (tlb_flush)
                for (int i = 0; i < N; i++) begin
                    m_live[i] = 1'b0; m_v[i] = 1'b0; m_g[i] = 1'b0;
                end
            if (tlb_we) begin
                m_vpn[tlb_index] = tlb_vpn; m_asid[tlb_index] = tlb_asid;
                m_pfn[tlb_index] = tlb_pfn; m_live[tlb_index] = 1'b1;
                m_g[tlb_index] = tlb_g; m_v[tlb_index] = tlb_v;
                m_d[tlb_index] = tlb_d; m_c[tlb_index] = tlb_c;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] va, input logic wr, input logic [AW-1:0] asid);
        int n;
        n = 0;
        req_valid = 1'b1; req_vaddr = va; req_wr = wr; cur_asid = asid;
        do begin
            step();
            n++;
        end while (!prev_acc && n < 20);
        check("accept_bound", 32'(prev_acc), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wr_ent(input logic [IW-1:0] idx, input logic [19:0] vpn, input logic [AW-1:0] asid,
                          input logic g, input logic [19:0] pfn, input logic v, input logic d,
                          input logic c, input logic flush);
        tlb_we = 1'b1; tlb_index = idx; tlb_vpn = vpn; tlb_asid = asid; tlb_g = g;
        tlb_pfn = pfn; tlb_v = v; tlb_d = d; tlb_c = c; tlb_flush = flush;
        step();
        tlb_we = 1'b0; tlb_flush = 1'b0;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    logic        held = 1'b0;
    logic [31:0] h_paddr;
    logic [3:0]  h_flags;

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("paddr", resp_paddr, e.paddr);
                check("uncached", 32'(resp_uncached), 32'(e.unc));
                check("miss", 32'(resp_miss), 32'(e.miss));
                check("invalid", 32'(resp_invalid), 32'(e.inv));
                check("modified", 32'(resp_modified), 32'(e.mod));
            end
        end
        if (!rst && resp_valid && !resp_ready) begin
            if (held) begin
                check("hold_paddr", resp_paddr, h_paddr);
                check("hold_flags", 32'({resp_uncached, resp_miss, resp_invalid, resp_modified}),
                      32'(h_flags));
            end
            held    = 1'b1;
            h_paddr = resp_paddr;
            h_flags = {resp_uncached, resp_miss, resp_invalid, resp_modified};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_wr = 1'b0; cur_asid = '0;
        resp_ready = 1'b1; tlb_we = 1'b0; tlb_index = '0; tlb_vpn = '0; tlb_asid = '0;
        tlb_g = 1'b0; tlb_pfn = '0; tlb_v = 1'b0; tlb_d = 1'b0; tlb_c = 1'b0; tlb_flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_vpn[i] = '0; m_asid[i] = '0; m_pfn[i] = '0; m_live[i] = 1'b0;
            m_g[i] = 1'b0; m_v[i] = 1'b0; m_d[i] = 1'b0; m_c[i] = 1'b0;
        end
        step(); step();
        rst = 1'b0;

        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_paddr", resp_paddr, 32'd0);
        check("rst_flags", 32'({resp_uncached, resp_miss, resp_invalid, resp_modified}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);

        // Fixed segments.
        send(32'hBFC0_0000, 1'b0, 8'd0);
        send(32'h8000_1234, 1'b0, 8'd0);
        drain(2);

        // ASID-qualified entry.
        send(32'h0040_0010, 1'b0, 8'd5);
        wr_ent(3'd3, 20'h00400, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b1, 1'b1, 1'b0);
        send(32'h0040_0010, 1'b0, 8'd5);
        send(32'h0040_0010, 1'b0, 8'd6);

        // Global clean page, invalid page, duplicate match, kseg2 miss.
        wr_ent(3'd1, 20'h7FFF0, 8'd0, 1'b1, 20'h0BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
        send(32'h7FFF_0008, 1'b1, 8'd9);
        send(32'h7FFF_0008, 1'b0, 8'd9);
        wr_ent(3'd2, 20'h00123, 8'd7, 1'b1, 20'h55555, 1'b0, 1'b1, 1'b1, 1'b0);
        send(32'h0012_3ABC, 1'b0, 8'd3);
        wr_ent(3'd5, 20'h00400, 8'd5, 1'b0, 20'h54321, 1'b1, 1'b1, 1'b1, 1'b0);
        send(32'h0040_0020, 1'b0, 8'd5);
        send(32'hC000_1000, 1'b0, 8'd0);

        // Write and lookup in the same cycle: lookup sees the old contents.
        tlb_we = 1'b1; tlb_index = 3'd4; tlb_vpn = 20'h00600; tlb_asid = 8'd0; tlb_g = 1'b1;
        tlb_pfn = 20'hAAAAA; tlb_v = 1'b1; tlb_d = 1'b1; tlb_c = 1'b0; tlb_flush = 1'b0;
        send(32'h0060_0004, 1'b0, 8'd0);
        tlb_we = 1'b0;
        send(32'h0060_0004, 1'b0, 8'd0);
        drain(2);

        // Consumer stall with a pending request.
        resp_ready = 1'b0;
        send(32'h8000_0040, 1'b0, 8'd0);
        req_valid = 1'b1; req_vaddr = 32'hA000_0080; req_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_valid", 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        send(32'hA000_0080, 1'b0, 8'd0);

        // Back-to-back throughput.
        send(32'h8000_0100, 1'b0, 8'd0);
        send(32'hA000_0200, 1'b0, 8'd0);
        send(32'h0040_0300, 1'b1, 8'd5);
        send(32'h7FFF_0400, 1'b0, 8'd1);
        drain(2);

        // Flush together with a write to entry 0.
        wr_ent(3'd0, 20'h00500, 8'd1, 1'b0, 20'h0ABCD, 1'b1, 1'b1, 1'b1, 1'b1);
        send(32'h0050_0ABC, 1'b0, 8'd1);
        send(32'h0040_0010, 1'b0, 8'd5);
        send(32'h7FFF_0008, 1'b0, 8'd0);
        send(32'h0060_0004, 1'b0, 8'd0);
        drain(2);

        // Reset while a result is pending.
        resp_ready = 1'b0;
        send(32'h0050_0ABC, 1'b0, 8'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drop_valid", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        send(32'h0050_0ABC, 1'b0, 8'd1);
        send(32'h0040_0010, 1'b0, 8'd5);
        drain(2);

        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
- Successor to the fixed-mapping address translator.
- Translates 32-bit MIPS virtual addresses to physical addresses behind a one-stage registered valid/ready pipeline. kseg0 and kseg1 keep the fixed unmapped translation; every other segment is looked up in a parametrised, fully-associative TLB.
- Sits between the fetch/LSU request and the SRAM-side bus. Reports cached/uncached attribute and TLB miss, invalid and modified faults to the pipeline.

Parameters:
- TLB_ENTRIES, 8: number of TLB entries; power of two, 2..32.
- ASID_W, 8: address-space ID width.
- IDX_W, $clog2(TLB_ENTRIES): TLB index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  translation request valid
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_vaddr  in  32  virtual address
- req_wr  in  1  request is a store
- cur_asid  in  ASID_W  current ASID, sampled with the request
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer takes result
- resp_paddr  out  32  physical address
- resp_uncached  out  1  access is uncached
- resp_miss  out  1  TLB refill fault
- resp_invalid  out  1  TLB invalid fault
- resp_modified  out  1  TLB modified fault (store to clean page)
- tlb_we  in  1  write entry
- tlb_index  in  IDX_W  entry to write
- tlb_vpn  in  20  VPN (4 KiB pages)
- tlb_asid  in  ASID_W  entry ASID
- tlb_g  in  1  global
- tlb_pfn  in  20  PFN
- tlb_v, tlb_d, tlb_c  in  1 each  valid, dirty, cacheable
- tlb_flush  in  1  clear V and G of all entries

Behaviour:
- Reset: resp_valid=0; resp_paddr=0; all fault flags and resp_uncached =0; all entries V=0, G=0. Other entry fields are don't-care.
- req_ready = !resp_valid || resp_ready (combinational). A request is accepted on req_valid && req_ready.
- Latency: exactly 1 cycle. All resp_* fields are registered on accept and held stable while resp_valid && !resp_ready.
- Back-to-back accepts give 1 result per cycle. With resp_valid=1 and resp_ready=0, no accept occurs and the outputs do not change.
- If a cycle has resp_ready && resp_valid and no accept, resp_valid goes to 0 on the next edge.
- Segment decode on vaddr[31:29]:
  - 100 (kseg0): paddr={3'b000,vaddr[28:0]}, uncached=0, no faults.
  - 101 (kseg1): paddr={3'b000,vaddr[28:0]}, uncached=1, no faults.
  - Any other value: TLB lookup.
- Match condition: entry.vpn==vaddr[31:12] && (entry.g || entry.asid==cur_asid).
- Multiple hits: the lowest index wins (deterministic; software must not rely on it).
- Lookup outcome, with fault priority miss > invalid > modified; at most one fault flag is set:
  - No match: miss=1, paddr=0, uncached=0.
  - Match with V=0: invalid=1, paddr=0.
  - Match with V=1, req_wr=1, D=0: modified=1, paddr={pfn,vaddr[11:0]}.
  - Otherwise: paddr={pfn,vaddr[11:0]}, uncached=~C.
- TLB update: tlb_we writes all fields of entry tlb_index on the edge.
  - A lookup accepted in the same cycle sees the old contents.
  - tlb_flush applies first. If tlb_we is also high, the written entry holds the written values after the edge.
- rst has priority over everything. Reset mid-transaction drops the pending result; resp_valid=0 on the next cycle.

Optional Feature:
- Macro: MMU_TLB_EN.
- Defined: full behaviour above.
- Undefined: no TLB storage is built and the tlb_* inputs are ignored. Non-kseg0/1 addresses translate by identity (paddr=vaddr), uncached=0, all fault flags 0. Pipeline and handshake behaviour are unchanged.

Test Plan:
- Reset, then vaddr=0xBFC00000 → one cycle later resp_valid=1, paddr=0x1FC00000, uncached=1. vaddr=0x80001234 → paddr=0x00001234, uncached=0.
- No TLB writes, vaddr=0x00400010 → miss=1, paddr=0. Then write idx 3: vpn=0x00400, asid=5, g=0, pfn=0x12345, v=1, d=1, c=1. Repeat with cur_asid=5 → paddr=0x12345010, uncached=0, no fault. Repeat with cur_asid=6 → miss=1.
- Entry with v=1, d=0, g=1, vpn=0x7FFF0. Store to 0x7FFF0008 → modified=1. Load to the same address → no fault.
- Hold resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and resp_* stable throughout. Release → the next request completes 1 cycle after acceptance; 4 back-to-back requests with resp_ready=1 give 4 consecutive resp_valid cycles in order.
- tlb_flush and tlb_we (idx 0) in the same cycle → entry 0 hits, all other previously valid entries miss. Assert rst while resp_valid=1 → resp_valid=0 next cycle and all lookups miss.
- Build without MMU_TLB_EN: vaddr=0x00400010 → paddr=0x00400010, no faults.
